// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline: control-word layout and the NOP control value.
package pipeline_pkg;

    localparam int CTRL_W = 9;

    // Bit positions inside the packed control word, MSB first.
    localparam int CTRL_REG_DEST   = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_ALU_OP1    = 5;
    localparam int CTRL_ALU_OP2    = 4;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_ALU_SRC    = 2;
    localparam int CTRL_REG_WRITE  = 1;
    localparam int CTRL_SPARE      = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detector: flags an ID instruction that reads the register a load in EX is writing.
module hazard_unit #(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ext_stall,
    output logic             hz,
    output logic             pc_write,
    output logic             ifid_write
);

    // $zero is never a real dependency, and both sources are compared even for I-type rt.
    always_comb begin
        hz = ex_valid & ex_mem_read & id_valid & (ex_rt != '0) &
             ((ex_rt == id_rs) | (ex_rt == id_rt));
        pc_write   = ~(ext_stall | hz);
        ifid_write = ~(ext_stall | hz);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              ext_stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic              pc_write,
    output logic              ifid_write,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic hz;

    hazard_unit #(
        .REG_W(REG_W)
    ) u_hazard (
        .ex_valid   (ex_valid),
        .ex_mem_read(ex_ctrl[CTRL_MEM_READ]),
        .ex_rt      (ex_rt),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ext_stall  (ext_stall),
        .hz         (hz),
        .pc_write   (pc_write),
        .ifid_write (ifid_write)
    );

    // ext_stall freezes everything, including a pending bubble, until memory catches up.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= CTRL_NOP;
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            bubble_cnt <= '0;
        end else if (!ext_stall) begin
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            if (hz) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= CTRL_NOP;
                if (bubble_cnt != {CNT_W{1'b1}})
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
            end else begin
                ex_valid <= id_valid;
                ex_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
            end
        end
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the 5-stage MIPS core. It registers the decoded control bits and operands from decode and presents them to execute. It also contains the load-use hazard detector, which stalls PC and IF/ID and injects a bubble into EX. A saturating counter records the number of bubbles inserted.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_W, 5, register-index width
- CNT_W, 16, bubble-counter width

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- id_valid  in  1  decode holds a real instruction
- id_ctrl  in  9  packed control: {reg_dest, mem_read, mem_to_reg, alu_op1, alu_op2, mem_write, alu_src, reg_write, valid_spare=0}, fields per package
- id_pc4  in  DATA_W  PC+4 of the decode instruction
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate (funct in [5:0])
- id_rs, id_rt, id_rd  in  REG_W  instruction register fields
- ext_stall  in  1  downstream hold (memory not ready); freezes the whole stage
- ex_valid  out  1  EX holds a real instruction (0 for a bubble)
- ex_ctrl  out  9  registered control
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands
- ex_rs, ex_rt, ex_rd  out  REG_W  registered indices (for forwarding and dest mux)
- pc_write  out  1  combinational; 0 holds the PC
- ifid_write  out  1  combinational; 0 holds IF/ID
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

## Operation
- Hazard condition (combinational): `hz = ex_valid & ex_ctrl.mem_read & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt))`.
  - Both source fields are always compared. Conservative stalls on I-type instructions whose rt is a destination are accepted.
- Each edge is evaluated in priority order; reset wins over everything.
  1. **reset:** every ex_* register = 0 and bubble_cnt = 0.
  2. **ext_stall=1:** all ex_* registers hold. pc_write=0 and ifid_write=0. No bubble is inserted and bubble_cnt holds, even if hz=1.
  3. **hz=1:** ex_ctrl is set to the package NOP constant (all zero) and ex_valid=0. Operand and index registers load normally; their values are don't-care. pc_write=0 and ifid_write=0. bubble_cnt increments, saturating at 2^CNT_W−1.
  4. **Otherwise:** all ex_* registers load from id_*. ex_valid=id_valid. If id_valid=0, ex_ctrl is forced to NOP. pc_write=1 and ifid_write=1.
- pc_write and ifid_write are always equal: `~(ext_stall | hz)`.

## Timing
- Latency: one cycle from id_* to ex_*.
- Reset values:
  - all ex_* = 0, ex_valid = 0, bubble_cnt = 0
  - pc_write = ifid_write = 1 after reset, since the registered state has mem_read=0
- Stall and bubble:
  - hz is asserted in the same cycle the dependent instruction sits in ID.
  - The bubble appears at ex_* on the next edge.
  - On that edge the load leaves EX, so hz deasserts and the dependent instruction loads on the following edge.
  - Exactly one bubble is inserted per load-use pair.
- Back-to-back loads feeding each other produce one bubble per pair; there is no cumulative stall.
- ext_stall asserted during hz: the stage holds, and the single bubble is inserted on the first edge where ext_stall=0.
- Counter wrap: none; the counter saturates.

## Structure
- pipeline_pkg holds:
  - CTRL_W = 9
  - bit-index constants for each id_ctrl field
  - CTRL_NOP = '0
- Sub-module hazard_unit: pure combinational hz, pc_write and ifid_write. The stage instantiates it once.
- The stage module holds the registers and bubble_cnt.

## Test plan
- **Reset:** drive id_* nonzero and hold reset for 2 cycles. Expect ex_valid=0, ex_ctrl=0, bubble_cnt=0, pc_write=1.
- **Passthrough:** R-format add r3=r1+r2, id_ctrl reg_dest=1, alu_op1=1, reg_write=1. One edge later, ex_* equal the inputs, ex_valid=1, pc_write stays 1.
- **Load-use:** lw r5,0(r1) followed by add r6,r5,r2.
  - Expect pc_write=ifid_write=0 for exactly one cycle.
  - EX sees lw, then a bubble (ex_ctrl=0, ex_valid=0), then add.
  - bubble_cnt=1.
- **$zero exclusion:** lw r0,0(r1) followed by add r6,r0,r2. Expect no stall and bubble_cnt unchanged.
- **ext_stall overlap:** load-use with ext_stall=1 for 3 cycles.
  - ex_* are frozen for those 3 cycles.
  - Then exactly one bubble, bubble_cnt +1, and the add issues afterwards.
- **Saturation:** preload via 2^CNT_W−1 hazards, or CNT_W=4 with 16 hazards. Expect bubble_cnt=15 and it stays at 15.
